// File: rtl/uart_frame_rx_param_if.sv
// Serial receiver bundle for uart_frame_rx_param.
//   signal        : synchronised serial line into the receiver, idle high
//   data          : data word of the last completed frame
//   valid         : one-cycle pulse, good frame with correct parity
//   error         : one-cycle pulse, good frame with parity mismatch
//   busy          : receiver is inside a frame
//   frame_err     : (UART_FRAME_ERR_EN only) one-cycle pulse on a bad stop bit
//   frame_err_cnt : (UART_FRAME_ERR_EN only) saturating count of frame_err
// Modports: master = receiver side, slave = frame consumer side.
// DATA_BITS must match the receiver instance it is connected to.
interface uart_frame_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 signal;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 error;
  logic                 busy;
`ifdef UART_FRAME_ERR_EN
  logic                 frame_err;
  logic [7:0]           frame_err_cnt;

  modport master (
    input  signal,
    output data, valid, error, busy, frame_err, frame_err_cnt
  );
  modport slave (
    output signal,
    input  data, valid, error, busy, frame_err, frame_err_cnt
  );
`else
  modport master (
    input  signal,
    output data, valid, error, busy
  );
  modport slave (
    output signal,
    input  data, valid, error, busy
  );
`endif
endinterface

// File: rtl/uart_frame_rx_param.sv
// Parametrised serial-frame receiver/checker. One line sample per clk,
// start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop
// bits. Good frames are reported with a one-cycle valid or error pulse.
//
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high reset
//   rx    : uart_frame_rx_param_if.master (signal in; data/valid/error/busy out)
//
// Parameters: DATA_BITS (1..16), PARITY_MODE (0 none, 1 odd, 2 even; 3 acts
// as none), STOP_BITS (1 or 2).
//
// Optional feature macro UART_FRAME_ERR_EN: adds frame_err (pulse on a stop
// bit sampled low) and frame_err_cnt (8-bit saturating count of those pulses).
//
// state | meaning
// BREAK | line low / after framing error, wait for a high sample
// IDLE  | line idle high, waiting for a start bit
// START | start bit seen, this sample is data bit 0
// DATA  | shifting in data bits 1..DATA_BITS-1
// PAR   | this sample is the parity bit
// STOP1 | this sample is the first stop bit
// STOP2 | this sample is the second stop bit
// DONE  | frame reported; this sample is already the next line bit
module uart_frame_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input logic                   clk,
  input logic                   reset,
  uart_frame_rx_param_if.master rx
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam int PM = (PARITY_MODE == 1 || PARITY_MODE == 2) ? PARITY_MODE : 0;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_BREAK, ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP1, ST_STOP2, ST_DONE
  } state_t;

  localparam state_t AFTER_DATA  = (PM == 0) ? ST_STOP1 : ST_PAR;
  localparam state_t AFTER_STOP1 = (STOP_BITS == 2) ? ST_STOP2 : ST_DONE;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_ok_q, par_ok_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;
`ifdef UART_FRAME_ERR_EN
  logic                 frame_err_q, frame_err_d;
  logic [7:0]           frame_err_cnt_q, frame_err_cnt_d;
`endif

  logic sig;
  assign sig = rx.signal;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    data_d   = data_q;

    case (state_q)
      ST_BREAK: if (sig) state_d = ST_IDLE;
      ST_IDLE:  if (!sig) state_d = ST_START;
      ST_START: begin
        // Right shift with the new bit at the MSB: after DATA_BITS samples
        // the first (LSB) bit has walked down to bit 0.
        shift_d                = shift_q >> 1;
        shift_d[DATA_BITS-1]   = sig;
        acc_d                  = sig;
        cnt_d                  = CW'(1);
        par_ok_d               = 1'b1;
        state_d                = (DATA_BITS == 1) ? AFTER_DATA : ST_DATA;
      end
      ST_DATA: begin
        shift_d              = shift_q >> 1;
        shift_d[DATA_BITS-1] = sig;
        acc_d                = acc_q ^ sig;
        cnt_d                = cnt_q + CW'(1);
        if (cnt_q == LAST_IDX) state_d = AFTER_DATA;
      end
      ST_PAR: begin
        par_ok_d = (PM == 1) ? (acc_q ^ sig) : ~(acc_q ^ sig);
        state_d  = ST_STOP1;
      end
      ST_STOP1: state_d = sig ? AFTER_STOP1 : ST_BREAK;
      ST_STOP2: state_d = sig ? ST_DONE : ST_BREAK;
      // The DONE sample belongs to the next frame, so a low here is a start bit.
      ST_DONE:  state_d = sig ? ST_IDLE : ST_START;
      default:  state_d = ST_BREAK;
    endcase

    if (state_d == ST_DONE) data_d = shift_q;

    valid_d = (state_d == ST_DONE) & par_ok_d;
    error_d = (state_d == ST_DONE) & ~par_ok_d;
    busy_d  = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_PAR) ||
              (state_d == ST_STOP1) || (state_d == ST_STOP2);
  end

`ifdef UART_FRAME_ERR_EN
  always_comb begin
    frame_err_d     = ((state_q == ST_STOP1) || (state_q == ST_STOP2)) & ~sig;
    frame_err_cnt_d = frame_err_cnt_q;
    if (frame_err_d && frame_err_cnt_q != 8'hFF) frame_err_cnt_d = frame_err_cnt_q + 8'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BREAK;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      shift_q  <= '0;
      par_ok_q <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      frame_err_q     <= 1'b0;
      frame_err_cnt_q <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shift_q  <= shift_d;
      par_ok_q <= par_ok_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
`ifdef UART_FRAME_ERR_EN
      frame_err_q     <= frame_err_d;
      frame_err_cnt_q <= frame_err_cnt_d;
`endif
    end
  end

  assign rx.data  = data_q;
  assign rx.valid = valid_q;
  assign rx.error = error_q;
  assign rx.busy  = busy_q;
`ifdef UART_FRAME_ERR_EN
  assign rx.frame_err     = frame_err_q;
  assign rx.frame_err_cnt = frame_err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_frame_rx_param.sv
module tb_uart_frame_rx_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_frame_rx_param_if #(.DATA_BITS(8)) bus0 ();
  uart_frame_rx_param_if #(.DATA_BITS(5)) bus1 ();

  uart_frame_rx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .rx(bus0.master));
  uart_frame_rx_param #(.DATA_BITS(5), .PARITY_MODE(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .rx(bus1.master));

  typedef struct {
    logic [15:0] d;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic prev_p0 = 1'b0;
  logic prev_p1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid/error pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (!reset && (bus0.valid || bus0.error)) begin
      chk("dut0_pulse_gap", 32'(prev_p0), 32'd0);
      chk("dut0_pulse_expected", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        chk("dut0_data", 32'(bus0.data), 32'(q0[0].d));
        chk("dut0_valid", 32'(bus0.valid), 32'(!q0[0].err));
        chk("dut0_error", 32'(bus0.error), 32'(q0[0].err));
        chk("dut0_latency", 32'(cyc), 32'(q0[0].cyc));
        void'(q0.pop_front());
      end
    end
    prev_p0 <= bus0.valid | bus0.error;
  end

  always @(negedge clk) begin
    if (!reset && (bus1.valid || bus1.error)) begin
      chk("dut1_pulse_gap", 32'(prev_p1), 32'd0);
      chk("dut1_pulse_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        chk("dut1_data", 32'(bus1.data), 32'(q1[0].d));
        chk("dut1_valid", 32'(bus1.valid), 32'(!q1[0].err));
        chk("dut1_error", 32'(bus1.error), 32'(q1[0].err));
        chk("dut1_latency", 32'(cyc), 32'(q1[0].cyc));
        void'(q1.pop_front());
      end
    end
    prev_p1 <= bus1.valid | bus1.error;
  end

  task automatic drive0(input logic b);
    bus0.signal = b;
    @(negedge clk);
  endtask

  task automatic drive1(input logic b);
    bus1.signal = b;
    @(negedge clk);
  endtask

  // kind: 0 = no pulse expected, 1 = valid, 2 = parity error.
  // Start bit is sampled at edge cyc+1; the pulse is seen at the negedge
  // following the last stop-bit edge, i.e. when cyc == start + N - 1.
  task automatic send0(input logic [7:0] d, input logic p, input logic s, input int kind);
    if (kind != 0) q0.push_back('{d: 16'(d), err: (kind == 2), cyc: cyc + 11});
    drive0(1'b0);
    for (int i = 0; i < 8; i++) drive0(d[i]);
    drive0(p);
    drive0(s);
  endtask

  task automatic send1(input logic [4:0] d, input logic p, input logic s1, input logic s2,
                       input int kind);
    if (kind != 0) q1.push_back('{d: 16'(d), err: (kind == 2), cyc: cyc + 9});
    drive1(1'b0);
    for (int i = 0; i < 5; i++) drive1(d[i]);
    drive1(p);
    drive1(s1);
    drive1(s2);
  endtask

  initial begin
    bus0.signal = 1'b1;
    bus1.signal = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_data0", 32'(bus0.data), 32'h0);
    chk("reset_valid0", 32'(bus0.valid), 32'h0);
    chk("reset_error0", 32'(bus0.error), 32'h0);
    chk("reset_busy0", 32'(bus0.busy), 32'h0);
    chk("reset_data1", 32'(bus1.data), 32'h0);
    chk("reset_busy1", 32'(bus1.busy), 32'h0);
`ifdef UART_FRAME_ERR_EN
    chk("reset_frame_err0", 32'(bus0.frame_err), 32'h0);
    chk("reset_frame_err_cnt0", 32'(bus0.frame_err_cnt), 32'h0);
`endif
    reset = 1'b0;

    // Good 0xA5 frame, odd parity
    drive0(1'b1);
    drive0(1'b1);
    send0(8'hA5, 1'b1, 1'b1, 1);
    chk("a5_data_at_done", 32'(bus0.data), 32'hA5);
    drive0(1'b1);
    chk("a5_busy_after", 32'(bus0.busy), 32'h0);
    chk("a5_valid_one_cycle", 32'(bus0.valid), 32'h0);

    // Same frame, wrong parity
    send0(8'hA5, 1'b0, 1'b1, 2);
    drive0(1'b1);
    chk("par_err_cleared", 32'(bus0.error), 32'h0);

    // Framing error: stop bit low after good parity
    send0(8'h3C, 1'b1, 1'b0, 0);
    chk("ferr_data_held", 32'(bus0.data), 32'hA5);
    chk("ferr_busy", 32'(bus0.busy), 32'h0);
`ifdef UART_FRAME_ERR_EN
    chk("ferr_pulse", 32'(bus0.frame_err), 32'h1);
    chk("ferr_cnt", 32'(bus0.frame_err_cnt), 32'h1);
`endif
    for (int i = 0; i < 3; i++) begin
      drive0(1'b0);
      chk("ferr_no_rearm_busy", 32'(bus0.busy), 32'h0);
    end
`ifdef UART_FRAME_ERR_EN
    chk("ferr_pulse_single", 32'(bus0.frame_err), 32'h0);
    chk("ferr_cnt_held", 32'(bus0.frame_err_cnt), 32'h1);
`endif
    drive0(1'b1);
    send0(8'h3C, 1'b1, 1'b1, 1);
    drive0(1'b1);

    // Back-to-back frames, no idle gap
    send0(8'hA5, 1'b1, 1'b1, 1);
    send0(8'h3C, 1'b1, 1'b1, 1);
    drive0(1'b1);
    chk("b2b_data_last", 32'(bus0.data), 32'h3C);

    // Five data bits, even parity, two stop bits
    drive1(1'b1);
    send1(5'h13, 1'b1, 1'b1, 1'b1, 1);
    drive1(1'b1);
    chk("p5_data", 32'(bus1.data), 32'h13);
    send1(5'h0A, 1'b0, 1'b1, 1'b0, 0);
    chk("p5_stop2_busy", 32'(bus1.busy), 32'h0);
    chk("p5_stop2_data_held", 32'(bus1.data), 32'h13);
`ifdef UART_FRAME_ERR_EN
    chk("p5_stop2_ferr", 32'(bus1.frame_err), 32'h1);
`endif
    drive1(1'b0);
    chk("p5_break_hold", 32'(bus1.busy), 32'h0);
    drive1(1'b1);
    send1(5'h0C, 1'b0, 1'b1, 1'b1, 1);
    send1(5'h13, 1'b0, 1'b1, 1'b1, 2);
    drive1(1'b1);

    // Reset while data bit 3 is being sampled
    drive0(1'b1);
    drive0(1'b0);
    drive0(1'b1);
    drive0(1'b0);
    drive0(1'b1);
    chk("midframe_busy", 32'(bus0.busy), 32'h1);
    bus0.signal = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_data0", 32'(bus0.data), 32'h0);
    chk("midrst_valid0", 32'(bus0.valid), 32'h0);
    chk("midrst_error0", 32'(bus0.error), 32'h0);
    chk("midrst_busy0", 32'(bus0.busy), 32'h0);
    chk("midrst_data1", 32'(bus1.data), 32'h0);
`ifdef UART_FRAME_ERR_EN
    chk("midrst_ferr_cnt0", 32'(bus0.frame_err_cnt), 32'h0);
`endif
    reset = 1'b0;
    drive0(1'b0);
    drive0(1'b0);
    chk("midrst_low_ignored", 32'(bus0.busy), 32'h0);
    drive0(1'b1);
    drive0(1'b1);
    send0(8'h5A, 1'b1, 1'b1, 1);
    drive0(1'b1);
    chk("midrst_new_frame", 32'(bus0.data), 32'h5A);

    repeat (5) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
